interrupt_interface: RTL and testbench
======================================

# interrupt_interface

Machine-mode interrupt interface between the CLINT and the commit stage. It registers the level interrupt requests from the CLINT and the external line, and exposes them as the `mip` view to the CSR file. It qualifies them with `mie` and `mstatus.MIE`, selects one cause by fixed priority, and holds a request/acknowledge handshake with commit until the trap is taken or the request is withdrawn.

## Interface
Parameters:
- `MCAUSE_WIDTH`, default `` `REG_DATA_WIDTH `` (32): width of the cause value presented to commit.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `all_intif_int_software_req` in 1: MSIP level from CLINT.
- `all_intif_int_timer_req` in 1: MTIP level from CLINT.
- `all_intif_int_ext_req` in 1: MEIP level from external source. Present only with `INTIF_EXT_INT_EN`.
- `csr_intif_mie_data` in `` `REG_DATA_WIDTH ``: current `mie`.
- `csr_intif_mstatus_data` in `` `REG_DATA_WIDTH ``: current `mstatus`; bit 3 is MIE.
- `intif_csr_mip_data` out `` `REG_DATA_WIDTH ``: registered pending bits. Bit 3 is MSIP, bit 7 is MTIP, bit 11 is MEIP; all other bits are 0.
- `intif_commit_has_interrupt` out 1: interrupt request to commit.
- `intif_commit_mcause_data` out `MCAUSE_WIDTH`: `{1'b1, zeros, cause}`, valid while the request is high.
- `commit_intif_ack` in 1: commit takes the trap this cycle.

## Operation
- Pending register `pend_q` (bits 11/7/3) samples the request inputs every cycle. `intif_csr_mip_data = pend_q`.
- `enabled = pend_q & mie[11,7,3] & {3{mstatus[3]}}`.
- Priority is MEI (11) > MSI (3) > MTI (7). `sel_cause` is the highest enabled bit.
- FSM states:
  - IDLE: if `enabled != 0`, latch `cause_q = sel_cause` and go to REQ.
  - REQ: `has_interrupt = 1` and `mcause` is driven from `cause_q`.
    - If `commit_intif_ack` is high, go to HOLD.
    - Otherwise, if bit `cause_q` of `enabled` is 0, go to IDLE (withdrawn).
    - Otherwise stay in REQ.
  - HOLD: a single cycle with `has_interrupt = 0`, giving the trap-entry CSR write to `mstatus` time to land. Then go to IDLE.
- No preemption: a higher-priority source arriving while in REQ does not change `cause_q`. It is serviced after return to IDLE.
- Ack and withdrawal in the same cycle: ack wins and the state goes to HOLD. Commit owns the trap once it has sampled the request.
- `commit_intif_ack` outside REQ is ignored.

## Timing
- Reset values: `pend_q = 0`, state IDLE, `cause_q = 0`, `intif_commit_has_interrupt = 0`, `intif_commit_mcause_data = 0`, `intif_csr_mip_data = 0`.
- Latency, with a source rising before edge N:
  - `mip` bit is visible after edge N.
  - `has_interrupt` is high after edge N+1, when already enabled.
- Acking at edge M:
  - `has_interrupt` is low after edge M and stays low after edge M+1 (HOLD).
  - The earliest re-request is after edge M+2.
- `mcause` outputs are registered and stable for the whole REQ interval.
- A reset asserted in any state forces IDLE immediately (asynchronous) and drops `has_interrupt` without waiting for a clock edge.
- A source pulse of one cycle is captured in `mip`. It raises a request only if enabled in the cycle the FSM is in IDLE with `pend_q` set.

## Configuration
- `INTIF_EXT_INT_EN` defined: the `all_intif_int_ext_req` port exists, MEIP is tracked in `pend_q[11]`, and it has top priority.
- `INTIF_EXT_INT_EN` undefined: the port is removed, `mip[11]` reads 0, and only MSI and MTI are arbitrated.

## Structure
- The shared package holds:
  - cause constants `INT_CAUSE_MSI = 3`, `INT_CAUSE_MTI = 7`, `INT_CAUSE_MEI = 11`;
  - `MSTATUS_MIE_BIT = 3`;
  - the FSM enum `intif_state_t` {IDLE, REQ, HOLD}.
- One sub-module, `int_priority_sel`, is natural: a purely combinational mapping from the 3-bit enabled vector to a valid flag plus cause. The top level keeps the registers and the FSM.

## Test plan
- Reset, then all requests 0 → `mip = 0`, `has_interrupt = 0` for 5 cycles.
- `mie = 0x80`, `mstatus = 0x8`, timer_req = 1 → `mip = 0x80` after 1 cycle; `has_interrupt = 1` with `mcause = 0x80000007` after 2 cycles.
- Software and timer both pending, both enabled → `mcause = 0x80000003`. After ack, with MIE cleared by the bench → `has_interrupt` low, and it stays low through HOLD.
- In REQ with MTI, drop timer_req without ack → `has_interrupt` low 2 cycles later (`mip` updates, then the FSM withdraws to IDLE).
- In REQ, raise ack and drop the enable in the same cycle → HOLD taken. The next request is no earlier than 2 cycles later.
- With `INTIF_EXT_INT_EN`: ext, software and timer all pending, `mie = 0x888` → `mcause = 0x8000000B`. Without the macro: `mip[11]` reads 0.

Source files
------------

// File: rtl/interrupt_interface_pkg.sv
// Shared definitions for the machine-mode interrupt interface: cause codes,
// pending-bit positions, the handshake FSM encoding and a cause lookup helper.
// Build option: INTIF_EXT_INT_EN enables the external interrupt (MEIP) path.

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package interrupt_interface_pkg;

    localparam int REG_DATA_WIDTH = `REG_DATA_WIDTH;
    localparam int CAUSE_WIDTH    = 4;

    // mcause exception codes for machine-mode interrupts
    localparam logic [CAUSE_WIDTH-1:0] INT_CAUSE_MSI = 4'd3;
    localparam logic [CAUSE_WIDTH-1:0] INT_CAUSE_MTI = 4'd7;
    localparam logic [CAUSE_WIDTH-1:0] INT_CAUSE_MEI = 4'd11;

    // Global interrupt enable inside mstatus
    localparam int MSTATUS_MIE_BIT = 3;

    // Bit positions of the pending/enable bits in mip/mie
    localparam int MIP_MSIP_BIT = 3;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    // Index of each source inside the compact 3-bit pending/enabled vectors
    localparam int SRC_MSI = 0;
    localparam int SRC_MTI = 1;
    localparam int SRC_MEI = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } intif_state_t;

    // True when the source that owns 'cause' is still enabled
    function automatic logic cause_is_enabled(input logic [2:0]             enabled,
                                              input logic [CAUSE_WIDTH-1:0] cause);
        logic hit;
        hit = 1'b0;
        case (cause)
            INT_CAUSE_MSI: hit = enabled[SRC_MSI];
            INT_CAUSE_MTI: hit = enabled[SRC_MTI];
            INT_CAUSE_MEI: hit = enabled[SRC_MEI];
            default:       hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/interrupt_interface_int_priority_sel.sv
// Fixed-priority selector: MEI > MSI > MTI. Purely combinational.
// Build option: INTIF_EXT_INT_EN (the MEI input is simply 0 when disabled).

module int_priority_sel
    import interrupt_interface_pkg::*;
(
    input  logic [2:0]             enabled,
    output logic                   valid,
    output logic [CAUSE_WIDTH-1:0] cause
);

    // Pick the highest-priority enabled source
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = 1'b0;
        cause = '0;
        if (enabled[SRC_MEI]) begin
            valid = 1'b1;
            cause = INT_CAUSE_MEI;
        end else if (enabled[SRC_MSI]) begin
            valid = 1'b1;
            cause = INT_CAUSE_MSI;
        end else if (enabled[SRC_MTI]) begin
            valid = 1'b1;
            cause = INT_CAUSE_MTI;
        end
    end

endmodule

// File: rtl/interrupt_interface.sv
// Machine-mode interrupt interface between the CLINT and commit.
// Registers the interrupt levels (mip view), qualifies them with mie and
// mstatus.MIE, selects a cause by fixed priority and runs a request/ack
// handshake with commit (IDLE -> REQ -> HOLD -> IDLE).
// Build option: define INTIF_EXT_INT_EN to add the external interrupt input.

module interrupt_interface
    import interrupt_interface_pkg::*;
#(
    parameter int MCAUSE_WIDTH = `REG_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       all_intif_int_software_req,
    input  logic                       all_intif_int_timer_req,
`ifdef INTIF_EXT_INT_EN
    input  logic                       all_intif_int_ext_req,
`endif
    input  logic [`REG_DATA_WIDTH-1:0] csr_intif_mie_data,
    input  logic [`REG_DATA_WIDTH-1:0] csr_intif_mstatus_data,
    output logic [`REG_DATA_WIDTH-1:0] intif_csr_mip_data,
    output logic                       intif_commit_has_interrupt,
    output logic [MCAUSE_WIDTH-1:0]    intif_commit_mcause_data,
    input  logic                       commit_intif_ack
);

    logic [2:0]             pend_d;
    logic [2:0]             pend_q;
    logic [2:0]             mie_bits;
    logic [2:0]             enabled;
    logic                   sel_valid;
    logic [CAUSE_WIDTH-1:0] sel_cause;
    intif_state_t           state_q;
    intif_state_t           state_d;
    logic [CAUSE_WIDTH-1:0] cause_q;
    logic [CAUSE_WIDTH-1:0] cause_d;

    // Raw request levels in compact source order
    always_comb begin
        pend_d          = '0;
        pend_d[SRC_MSI] = all_intif_int_software_req;
        pend_d[SRC_MTI] = all_intif_int_timer_req;
`ifdef INTIF_EXT_INT_EN
        pend_d[SRC_MEI] = all_intif_int_ext_req;
`endif
    end

    // Pending register samples the request levels every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            pend_q <= pend_d;
        end
    end

    // mip view: only MSIP/MTIP/MEIP can ever be set
    always_comb begin
        intif_csr_mip_data               = '0;
        intif_csr_mip_data[MIP_MSIP_BIT] = pend_q[SRC_MSI];
        intif_csr_mip_data[MIP_MTIP_BIT] = pend_q[SRC_MTI];
        intif_csr_mip_data[MIP_MEIP_BIT] = pend_q[SRC_MEI];
    end

    // Qualify pending sources with mie and the global enable
    always_comb begin
        mie_bits          = '0;
        mie_bits[SRC_MSI] = csr_intif_mie_data[MIP_MSIP_BIT];
        mie_bits[SRC_MTI] = csr_intif_mie_data[MIP_MTIP_BIT];
        mie_bits[SRC_MEI] = csr_intif_mie_data[MIP_MEIP_BIT];
        enabled           = pend_q & mie_bits & {3{csr_intif_mstatus_data[MSTATUS_MIE_BIT]}};
    end

    int_priority_sel u_int_priority_sel (
        .enabled (enabled),
        .valid   (sel_valid),
        .cause   (sel_cause)
    );

    // Handshake state and latched cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic: latch a cause in IDLE, hold it through REQ, one quiet HOLD cycle after ack
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = REQ;
                    cause_d = sel_cause;
                end
            end
            REQ: begin
                // Ack wins over a simultaneous withdrawal: commit already owns the trap
                if (commit_intif_ack) begin
                    state_d = HOLD;
                end else if (!cause_is_enabled(enabled, cause_q)) begin
                    state_d = IDLE;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registers so reset drops them without a clock edge
    always_comb begin
        intif_commit_has_interrupt = (state_q == REQ);
        intif_commit_mcause_data   = '0;
        if (state_q == REQ) begin
            intif_commit_mcause_data                  = MCAUSE_WIDTH'(cause_q);
            intif_commit_mcause_data[MCAUSE_WIDTH-1]  = 1'b1;
        end
    end

    // Only bits 3/7/11 of mie and bit 3 of mstatus are consumed
    logic unused_csr_bits;
    assign unused_csr_bits = ^{csr_intif_mie_data, csr_intif_mstatus_data};

endmodule

// File: tb/tb_interrupt_interface.sv
// Directed self-checking bench for interrupt_interface.
// Inputs change 1 time unit after a rising edge; outputs are checked there too,
// well away from the next active edge.

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module tb_interrupt_interface;

    logic        clk;
    logic        rst;
    logic        sw_req;
    logic        tim_req;
    logic        ext_req;
    logic [31:0] mie;
    logic [31:0] mstatus;
    logic [31:0] mip;
    logic        has_int;
    logic [31:0] mcause;
    logic        ack;

    int tests_run;
    int tests_failed;

    interrupt_interface #(.MCAUSE_WIDTH(32)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .all_intif_int_software_req (sw_req),
        .all_intif_int_timer_req    (tim_req),
`ifdef INTIF_EXT_INT_EN
        .all_intif_int_ext_req      (ext_req),
`endif
        .csr_intif_mie_data         (mie),
        .csr_intif_mstatus_data     (mstatus),
        .intif_csr_mip_data         (mip),
        .intif_commit_has_interrupt (has_int),
        .intif_commit_mcause_data   (mcause),
        .commit_intif_ack           (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        sw_req  = 1'b0;
        tim_req = 1'b0;
        ext_req = 1'b0;
        mie     = 32'h0;
        mstatus = 32'h0;
        ack     = 1'b0;

        #2;
        check("reset_mip", mip, 32'h0);
        check("reset_has_int", {31'b0, has_int}, 32'h0);
        check("reset_mcause", mcause, 32'h0);
        step();
        step();
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_mip", mip, 32'h0);
            check("idle_has_int", {31'b0, has_int}, 32'h0);
        end

        // Timer only: mip after 1 edge, request after 2
        mie     = 32'h80;
        mstatus = 32'h8;
        tim_req = 1'b1;
        step();
        check("tmr_mip", mip, 32'h80);
        check("tmr_has_int_early", {31'b0, has_int}, 32'h0);
        step();
        check("tmr_has_int", {31'b0, has_int}, 32'h1);
        check("tmr_mcause", mcause, 32'h8000_0007);

        // Withdraw: drop timer without ack
        tim_req = 1'b0;
        step();
        check("wd_mip", mip, 32'h0);
        check("wd_has_int_still", {31'b0, has_int}, 32'h1);
        check("wd_mcause_stable", mcause, 32'h8000_0007);
        step();
        check("wd_has_int_low", {31'b0, has_int}, 32'h0);
        check("wd_mcause_zero", mcause, 32'h0);

        // Software beats timer; ack with MIE cleared
        mie     = 32'h88;
        sw_req  = 1'b1;
        tim_req = 1'b1;
        step();
        check("prio_mip", mip, 32'h88);
        step();
        check("prio_has_int", {31'b0, has_int}, 32'h1);
        check("prio_mcause", mcause, 32'h8000_0003);
        ack     = 1'b1;
        mstatus = 32'h0;
        step();
        check("ack_has_int_low", {31'b0, has_int}, 32'h0);
        ack = 1'b0;
        step();
        check("hold_has_int_low", {31'b0, has_int}, 32'h0);
        step();
        check("mie_off_has_int_low", {31'b0, has_int}, 32'h0);

        // Ack and enable drop in the same cycle: HOLD, re-request at M+2
        mstatus = 32'h8;
        step();
        check("reen_has_int", {31'b0, has_int}, 32'h1);
        check("reen_mcause", mcause, 32'h8000_0003);
        ack = 1'b1;
        mie = 32'h0;
        step();
        check("ackwd_has_int_low", {31'b0, has_int}, 32'h0);
        ack = 1'b0;
        mie = 32'h88;
        step();
        check("ackwd_hold_low", {31'b0, has_int}, 32'h0);
        step();
        check("ackwd_rereq", {31'b0, has_int}, 32'h1);
        check("ackwd_rereq_mcause", mcause, 32'h8000_0003);

        // No preemption: MTI in REQ, then MSI arrives
        ack    = 1'b1;
        sw_req = 1'b0;
        step();
        check("np_ack_low", {31'b0, has_int}, 32'h0);
        ack = 1'b0;
        step();
        check("np_hold_low", {31'b0, has_int}, 32'h0);
        step();
        check("np_mti_req", {31'b0, has_int}, 32'h1);
        check("np_mti_cause", mcause, 32'h8000_0007);
        sw_req = 1'b1;
        step();
        check("np_mip_both", mip, 32'h88);
        check("np_cause_kept", mcause, 32'h8000_0007);
        step();
        check("np_cause_kept2", mcause, 32'h8000_0007);
        check("np_still_req", {31'b0, has_int}, 32'h1);

        // Asynchronous reset in REQ, checked between edges
        rst = 1'b1;
        #1;
        check("arst_has_int", {31'b0, has_int}, 32'h0);
        check("arst_mcause", mcause, 32'h0);
        check("arst_mip", mip, 32'h0);
        step();
        rst = 1'b0;

        // External source: top priority when built in, invisible otherwise
        ext_req = 1'b1;
        sw_req  = 1'b1;
        tim_req = 1'b1;
        mie     = 32'h888;
        mstatus = 32'h8;
        step();
`ifdef INTIF_EXT_INT_EN
        check("ext_mip", mip, 32'h888);
        step();
        check("ext_has_int", {31'b0, has_int}, 32'h1);
        check("ext_mcause", mcause, 32'h8000_000B);
`else
        check("noext_mip", mip, 32'h88);
        step();
        check("noext_has_int", {31'b0, has_int}, 32'h1);
        check("noext_mcause", mcause, 32'h8000_0003);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
